fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_pc_reg.sv | 38 +++
 rtl/fetch_seq.sv | 143 ++++++++++++++
 tb/tb_fetch_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: the state
// encoding, the fetch stride and the default boot address.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_HALT = 3'd4
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Redirect targets may carry junk in the low bits; fetch is word-only.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: synchronous reset, load (redirect/boot)
// and sequential increment. Load has priority over increment.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + 32'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: one outstanding memory request, holds the
// returned instruction for decode, handles redirects and self-loop halt.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  input  logic [31:0] redir_src_pc,
  output logic        halted,
  output logic [2:0]  dbg_state_o
);

  localparam logic [2:0] BOOT = ST_BOOT;
  localparam logic [2:0] REQ  = ST_REQ;
  localparam logic [2:0] WAIT = ST_WAIT;
  localparam logic [2:0] HOLD = ST_HOLD;
  localparam logic [2:0] HALT = ST_HALT;

  logic [2:0]  state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] if_pc_q, if_instr_q;
  logic [31:0] pc;
  logic        pc_load, pc_inc, rsp_latch;
  logic [31:0] pc_load_val;
  logic [31:0] redir_tgt;
  logic        self_loop;

  assign redir_tgt = align_word(redir_target);
  assign self_loop = redir_valid && (redir_tgt == redir_src_pc);

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pc_load),
    .load_val_i (pc_load_val),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  // Both handshakes transfer on a rising edge where valid && ready; a
  // valid source holds its payload stable until that edge (or a redirect).
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    pc_load     = 1'b0;
    pc_load_val = redir_tgt;
    pc_inc      = 1'b0;
    rsp_latch   = 1'b0;
    case (state_q)
      BOOT: begin
        pc_load     = 1'b1;
        pc_load_val = RESET_PC;
        kill_d      = 1'b0;
        state_d     = REQ;
      end
      REQ: begin
        if (redir_valid) begin
          pc_load = 1'b1;
        end
        if (imem_req_ready) begin
          state_d = WAIT;
          kill_d  = redir_valid;
        end
      end
      WAIT: begin
        if (redir_valid) begin
          pc_load = 1'b1;
          kill_d  = 1'b1;
        end
        // A killed response still has to drain before a new request goes out.
        if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (kill_q || redir_valid) begin
            state_d = REQ;
          end else begin
            rsp_latch = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (redir_valid) begin
          pc_load = 1'b1;
          state_d = REQ;
        end else if (if_ready) begin
          pc_inc  = 1'b1;
          state_d = REQ;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    if (self_loop && (state_q != HALT)) begin
      state_d   = HALT;
      kill_d    = 1'b0;
      pc_load   = 1'b0;
      pc_inc    = 1'b0;
      rsp_latch = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      kill_q     <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (rsp_latch) begin
        if_pc_q    <= pc;
        if_instr_q <= imem_rsp_data;
      end
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = imem_req_valid ? pc : '0;
  assign if_valid       = (state_q == HOLD);
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign halted         = (state_q == HALT);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a small instruction memory with selectable
// response latency, and a linear sequence of hand-checked steps.
module tb_fetch_seq;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic [31:0] redir_src_pc;
  logic        halted;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int mem_lat  = 1;
  int acc_cnt  = 0;
  int pend_cnt = 0;
  logic [31:0] pend_addr;

  fetch_seq #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (req_valid),
    .imem_req_addr  (req_addr),
    .imem_req_ready (req_ready),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .redir_valid    (redir_valid),
    .redir_target   (redir_target),
    .redir_src_pc   (redir_src_pc),
    .halted         (halted),
    .dbg_state_o    (dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'h1357_9BDF;
  endfunction

  // memory: accept seen mid-cycle, response mem_lat cycles after the accept edge
  initial begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      if (pend_cnt == 0 && req_valid && req_ready) begin
        pend_cnt  = mem_lat;
        pend_addr = req_addr;
        acc_cnt++;
      end
      @(posedge clk);
      #1;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_data  = mem_word(pend_addr);
        end else begin
          rsp_valid = 1'b0;
        end
      end else begin
        rsp_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From REQ at exp_pc with ready/if_ready high and 1-cycle memory.
  task automatic fetch_one(input logic [31:0] exp_pc);
    chk("req_valid", {31'd0, req_valid}, 32'd1);
    chk("req_addr", req_addr, exp_pc);
    tick();
    chk("wait_if_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("hold_if_valid", {31'd0, if_valid}, 32'd1);
    chk("hold_if_pc", if_pc, exp_pc);
    chk("hold_if_instr", if_instr, mem_word(exp_pc));
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    req_ready    = 1'b1;
    if_ready     = 1'b1;
    redir_valid  = 1'b0;
    redir_target = '0;
    redir_src_pc = '0;

    // reset state
    tick();
    tick();
    chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_BOOT});
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_req_addr", req_addr, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;
    tick();

    // streaming fetch, first if_valid three edges after reset release
    fetch_one(32'h0);
    fetch_one(32'h4);

    // memory stall at 0x8
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req_valid", {31'd0, req_valid}, 32'd1);
      chk("stall_req_addr", req_addr, 32'h8);
    end
    chk("stall_acc_cnt", acc_cnt, 32'd2);
    req_ready = 1'b1;
    fetch_one(32'h8);
    chk("acc_after_stall", acc_cnt, 32'd3);

    // redirect while waiting on 0xC; its response must be dropped
    mem_lat = 2;
    chk("req_addr_c", req_addr, 32'hC);
    tick();
    chk("wait_c_state", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    redir_valid  = 1'b1;
    redir_target = 32'h40;
    redir_src_pc = 32'hC;
    tick();
    redir_valid = 1'b0;
    chk("kill_wait_state", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    chk("kill_if_valid0", {31'd0, if_valid}, 32'd0);
    tick();
    mem_lat = 1;
    chk("kill_if_valid1", {31'd0, if_valid}, 32'd0);
    chk("kill_next_addr", req_addr, 32'h40);
    fetch_one(32'h40);

    // redirect in HOLD beats if_ready; target low bits cleared
    chk("req_addr_44", req_addr, 32'h44);
    tick();
    tick();
    chk("hold44_if_pc", if_pc, 32'h44);
    redir_valid  = 1'b1;
    redir_target = 32'h12;
    redir_src_pc = 32'h44;
    tick();
    redir_valid = 1'b0;
    if_ready    = 1'b0;
    chk("hold_redir_if_valid", {31'd0, if_valid}, 32'd0);
    chk("hold_redir_addr", req_addr, 32'h10);

    // decode back-pressure at 0x10
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_if_valid", {31'd0, if_valid}, 32'd1);
      chk("bp_if_pc", if_pc, 32'h10);
      chk("bp_if_instr", if_instr, mem_word(32'h10));
      chk("bp_req_valid", {31'd0, req_valid}, 32'd0);
      tick();
    end
    if_ready = 1'b1;
    tick();
    chk("bp_next_addr", req_addr, 32'h14);

    // redirect in REQ without accept
    req_ready    = 1'b0;
    redir_valid  = 1'b1;
    redir_target = 32'h100;
    redir_src_pc = 32'h14;
    tick();
    redir_valid = 1'b0;
    req_ready   = 1'b1;
    chk("req_redir_state", {29'd0, dbg_state}, {29'd0, ST_REQ});
    fetch_one(32'h100);

    // redirect coincident with accept, then pc wrap
    redir_valid  = 1'b1;
    redir_target = 32'hFFFF_FFFC;
    redir_src_pc = 32'h104;
    tick();
    redir_valid = 1'b0;
    chk("coinc_state", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    tick();
    chk("coinc_if_valid", {31'd0, if_valid}, 32'd0);
    fetch_one(32'hFFFF_FFFC);
    chk("wrap_addr", req_addr, 32'h0);
    chk("acc_before_halt", acc_cnt, 32'd10);

    // self-loop halt
    req_ready    = 1'b0;
    redir_valid  = 1'b1;
    redir_target = 32'h6C;
    redir_src_pc = 32'h6C;
    tick();
    redir_valid = 1'b0;
    req_ready   = 1'b1;
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_state", {29'd0, dbg_state}, {29'd0, ST_HALT});
    chk("halt_if_valid", {31'd0, if_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_req_valid", {31'd0, req_valid}, 32'd0);
    end
    redir_valid  = 1'b1;
    redir_target = 32'h200;
    redir_src_pc = 32'h0;
    tick();
    redir_valid = 1'b0;
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    chk("halt_acc_cnt", acc_cnt, 32'd10);

    // reset leaves HALT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_state", {29'd0, dbg_state}, {29'd0, ST_BOOT});
    chk("rst2_if_pc", if_pc, 32'd0);
    tick();
    chk("rst2_req_valid", {31'd0, req_valid}, 32'd1);
    chk("rst2_addr", req_addr, 32'h0);

    // reset during WAIT, late response must be ignored
    mem_lat = 2;
    tick();
    chk("rst3_wait", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    mem_lat = 1;
    chk("rst3_state", {29'd0, dbg_state}, {29'd0, ST_BOOT});
    chk("rst3_if_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("rst3_drop_if_valid", {31'd0, if_valid}, 32'd0);
    fetch_one(32'h0);
    chk("final_acc_cnt", acc_cnt, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
